// File: rtl/rv32_mem_pkg.sv
// Shared types for the RV32 misaligned load/store sequencer: FSM states,
// access-size encodings and the byte-lane mask helper.
package rv32_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACC0,
      ST_WAIT0,
      ST_ACC1,
      ST_WAIT1,
      ST_RESP
   } seq_state_e;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Lanes touched across two consecutive words; bits [7:4] belong to the second word.
   function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [7:0] base;
      case (size)
         SIZE_BYTE: base = 8'b0000_0001;
         SIZE_HALF: base = 8'b0000_0011;
         default:   base = 8'b0000_1111;
      endcase
      return base << off;
   endfunction

endpackage

// File: rtl/rv32_m_load_align.sv
// Merges the two fetched words, right-justifies the addressed bytes and
// applies sign or zero extension according to funct3.
module rv32_m_load_align
   import rv32_mem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] lo_i,
   input  logic [23:0] hi_i,
   output logic [31:0] rdata_o
);

   logic [31:0] shifted;

   // The top byte of the high word can never be part of a 4-byte access.
   always_comb begin
      case (off_i)
         2'd0:    shifted = lo_i;
         2'd1:    shifted = {hi_i[7:0],  lo_i[31:8]};
         2'd2:    shifted = {hi_i[15:0], lo_i[31:16]};
         default: shifted = {hi_i[23:0], lo_i[31:24]};
      endcase
   end

   always_comb begin
      case (funct3_i[1:0])
         SIZE_BYTE: rdata_o = funct3_i[2] ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
         SIZE_HALF: rdata_o = funct3_i[2] ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
         default:   rdata_o = shifted;
      endcase
   end

endmodule

// File: rtl/rv32_m_misaligned_sequencer.sv
// Splits byte/half/word accesses at any alignment into one or two
// word-aligned memory transactions and returns the extended load result.
//
// state  | meaning
// IDLE   | ready for a request
// ACC0   | first (or only) word request pending grant
// WAIT0  | waiting for first word completion
// ACC1   | second word request pending grant
// WAIT1  | waiting for second word completion
// RESP   | one-cycle response pulse
module rv32_m_misaligned_sequencer
   import rv32_mem_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   seq_state_e  state_q, state_d;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q, buf_lo_q, rsp_rdata_q;
   logic [23:0] buf_hi_q;

   logic [1:0]  off;
   logic [7:0]  mask;
   logic        split;
   logic [63:0] wpos;
   logic [31:0] addr0, addr1, load_data, resp_data;

   assign off   = addr_q[1:0];
   assign mask  = lane_mask(f3_q[1:0], off);
   assign split = |mask[7:4];
   assign wpos  = {32'h0, wdata_q} << {off, 3'b000};
   assign addr0 = {addr_q[31:2], 2'b00};
   assign addr1 = addr0 + 32'd4;

   rv32_m_load_align u_align (
      .funct3_i (f3_q),
      .off_i    (off),
      .lo_i     (buf_lo_q),
      .hi_i     (buf_hi_q),
      .rdata_o  (load_data)
   );

   assign resp_data   = we_q ? 32'h0 : load_data;
   assign rsp_rdata_o = (state_q == ST_RESP) ? resp_data : rsp_rdata_q;
   assign mem_we_o    = we_q;

   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      mem_req_o   = 1'b0;
      mem_addr_o  = addr0;
      mem_be_o    = mask[3:0];
      mem_wdata_o = wpos[31:0];
      case (state_q)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) state_d = ST_ACC0;
         end
         ST_ACC0: begin
            mem_req_o = 1'b1;
            if (mem_gnt_i) state_d = ST_WAIT0;
         end
         ST_WAIT0: begin
            if (mem_rvalid_i) state_d = split ? ST_ACC1 : ST_RESP;
         end
         ST_ACC1: begin
            mem_req_o   = 1'b1;
            mem_addr_o  = addr1;
            mem_be_o    = mask[7:4];
            mem_wdata_o = wpos[63:32];
            if (mem_gnt_i) state_d = ST_WAIT1;
         end
         ST_WAIT1: begin
            mem_addr_o  = addr1;
            mem_be_o    = mask[7:4];
            mem_wdata_o = wpos[63:32];
            if (mem_rvalid_i) state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid_o = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         f3_q        <= 3'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         buf_lo_q    <= 32'h0;
         buf_hi_q    <= 24'h0;
         rsp_rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && req_valid_i) begin
            we_q    <= req_we_i;
            f3_q    <= req_funct3_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
         end
         if (state_q == ST_WAIT0 && mem_rvalid_i) buf_lo_q <= mem_rdata_i;
         if (state_q == ST_WAIT1 && mem_rvalid_i) buf_hi_q <= mem_rdata_i[23:0];
         if (state_q == ST_RESP) rsp_rdata_q <= resp_data;
      end
   end

endmodule

// File: tb/tb_rv32_m_misaligned_sequencer.sv
// Directed bench for the misaligned sequencer: a task-driven memory
// responder services each access and every scenario checks its own results.
module tb_rv32_m_misaligned_sequencer;

   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic        req_valid_i = 1'b0, req_we_i = 1'b0;
   logic [2:0]  req_funct3_i = 3'b0;
   logic [31:0] req_addr_i = 32'h0, req_wdata_i = 32'h0;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = 32'h0;
   logic        req_ready_o, rsp_valid_o, mem_req_o, mem_we_o;
   logic [31:0] rsp_rdata_o, mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;

   rv32_m_misaligned_sequencer dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int total = 0, bad = 0;

   logic [31:0] o_addr [2];
   logic [3:0]  o_be   [2];
   logic [31:0] o_wd   [2];
   logic        o_we   [2];
   logic [31:0] o_rdata;
   int          o_nacc, o_lat, o_unstable;
   logic        o_timeout, o_ready_at_req, o_after_valid, o_after_ready;

   // Called at a falling edge; issues one request, services its accesses and
   // returns at the falling edge after the response pulse.
   task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1,
                          input int gd0, input int gd1);
      int acc_cyc, gd;
      bit done;
      logic [31:0] sa, sw, rd;
      logic [3:0]  sb;
      logic        swe;
      o_nacc = 0; o_unstable = 0; o_timeout = 1'b0; o_lat = 0; o_rdata = 32'hx;
      o_ready_at_req = req_ready_o;
      req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wdata;
      acc_cyc = cyc;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      done = 1'b0;
      for (int t = 0; t < 60 && !done; t++) begin
         if (rsp_valid_o === 1'b1) begin
            o_rdata = rsp_rdata_o; o_lat = cyc - acc_cyc + 1; done = 1'b1;
         end else if (mem_req_o === 1'b1 && o_nacc < 2) begin
            gd = (o_nacc == 0) ? gd0 : gd1;
            rd = (o_nacc == 0) ? rd0 : rd1;
            sa = mem_addr_o; sb = mem_be_o; sw = mem_wdata_o; swe = mem_we_o;
            for (int h = 0; h < gd; h++) begin
               if (mem_addr_o !== sa || mem_be_o !== sb || mem_wdata_o !== sw ||
                   mem_we_o !== swe || mem_req_o !== 1'b1 || req_ready_o !== 1'b0)
                  o_unstable++;
               @(negedge clk_i);
            end
            if (mem_addr_o !== sa || mem_be_o !== sb || mem_wdata_o !== sw || mem_req_o !== 1'b1)
               o_unstable++;
            o_addr[o_nacc] = mem_addr_o; o_be[o_nacc] = mem_be_o;
            o_wd[o_nacc] = mem_wdata_o; o_we[o_nacc] = mem_we_o;
            mem_gnt_i = 1'b1;
            @(negedge clk_i);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = rd;
            @(negedge clk_i);
            mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
            o_nacc++;
         end else begin
            @(negedge clk_i);
         end
      end
      if (!done) o_timeout = 1'b1;
      @(negedge clk_i);
      o_after_valid = rsp_valid_o; o_after_ready = req_ready_o;
   endtask

   task automatic test_reset();
      @(negedge clk_i); @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", req_ready_o); end
      total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", mem_req_o); end
      total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid_o); end
      total++; if (rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rsp_rdata_o); end
   endtask

   task automatic test_lw_aligned();
      run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0);
      total++; if (o_timeout) begin bad++; $display("FAIL lw_timeout got=1 want=0"); end
      total++; if (o_nacc !== 1) begin bad++; $display("FAIL lw_nacc got=%0d want=1", o_nacc); end
      total++; if (o_addr[0] !== 32'h100 || o_be[0] !== 4'b1111 || o_we[0] !== 1'b0) begin bad++;
         $display("FAIL lw_access got=%h/%b/%b want=00000100/1111/0", o_addr[0], o_be[0], o_we[0]); end
      total++; if (o_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h want=deadbeef", o_rdata); end
      total++; if (o_lat !== 4) begin bad++; $display("FAIL lw_latency got=%0d want=4", o_lat); end
      total++; if (o_after_valid !== 1'b0 || o_after_ready !== 1'b1) begin bad++;
         $display("FAIL lw_pulse got=%b/%b want=0/1", o_after_valid, o_after_ready); end
      repeat (3) @(negedge clk_i);
      total++; if (rsp_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_hold got=%h want=deadbeef", rsp_rdata_o); end
   endtask

   task automatic test_lh_split();
      for (int k = 0; k < 2; k++) begin
         run_txn(1'b0, (k == 0) ? 3'b001 : 3'b101, 32'h103, 32'h0, 32'h80112233, 32'h4455667F, 0, 0);
         total++; if (o_timeout || o_nacc !== 2) begin bad++; $display("FAIL lh_nacc%0d got=%0d want=2", k, o_nacc); end
         total++; if (o_addr[0] !== 32'h100 || o_be[0] !== 4'b1000) begin bad++;
            $display("FAIL lh_acc0_%0d got=%h/%b want=00000100/1000", k, o_addr[0], o_be[0]); end
         total++; if (o_addr[1] !== 32'h104 || o_be[1] !== 4'b0001) begin bad++;
            $display("FAIL lh_acc1_%0d got=%h/%b want=00000104/0001", k, o_addr[1], o_be[1]); end
         total++; if (o_rdata !== 32'h00007F80) begin bad++; $display("FAIL lh_rdata%0d got=%h want=00007f80", k, o_rdata); end
         total++; if (o_lat !== 6) begin bad++; $display("FAIL lh_latency%0d got=%0d want=6", k, o_lat); end
      end
   endtask

   task automatic test_sw_split();
      run_txn(1'b1, 3'b010, 32'h102, 32'h11223344, 32'hAAAAAAAA, 32'h55555555, 0, 0);
      total++; if (o_timeout || o_nacc !== 2) begin bad++; $display("FAIL sw_nacc got=%0d want=2", o_nacc); end
      total++; if (o_addr[0] !== 32'h100 || o_be[0] !== 4'b1100 || o_we[0] !== 1'b1) begin bad++;
         $display("FAIL sw_acc0 got=%h/%b/%b want=00000100/1100/1", o_addr[0], o_be[0], o_we[0]); end
      total++; if ((o_wd[0] & 32'hFFFF0000) !== 32'h33440000) begin bad++; $display("FAIL sw_wd0 got=%h want=3344xxxx", o_wd[0]); end
      total++; if (o_addr[1] !== 32'h104 || o_be[1] !== 4'b0011 || o_we[1] !== 1'b1) begin bad++;
         $display("FAIL sw_acc1 got=%h/%b/%b want=00000104/0011/1", o_addr[1], o_be[1], o_we[1]); end
      total++; if ((o_wd[1] & 32'h0000FFFF) !== 32'h00001122) begin bad++; $display("FAIL sw_wd1 got=%h want=xxxx1122", o_wd[1]); end
      total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL sw_rdata got=%h want=0", o_rdata); end
   endtask

   task automatic test_byte_loads();
      logic [31:0] exp [2];
      exp[0] = 32'hFFFFFFF0; exp[1] = 32'h000000F0;
      for (int k = 0; k < 2; k++) begin
         run_txn(1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h1, 32'h0, 32'h1234F056, 32'h0, 0, 0);
         total++; if (o_nacc !== 1 || o_addr[0] !== 32'h0 || o_be[0] !== 4'b0010) begin bad++;
            $display("FAIL lb_access%0d got=%0d/%h/%b want=1/00000000/0010", k, o_nacc, o_addr[0], o_be[0]); end
         total++; if (o_rdata !== exp[k]) begin bad++; $display("FAIL lb_rdata%0d got=%h want=%h", k, o_rdata, exp[k]); end
      end
   endtask

   task automatic test_wrap();
      run_txn(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h5678ABCD, 32'h11119999, 0, 0);
      total++; if (o_nacc !== 2 || o_addr[0] !== 32'hFFFFFFFC || o_be[0] !== 4'b1100) begin bad++;
         $display("FAIL wrap_acc0 got=%0d/%h/%b want=2/fffffffc/1100", o_nacc, o_addr[0], o_be[0]); end
      total++; if (o_addr[1] !== 32'h0 || o_be[1] !== 4'b0011) begin bad++;
         $display("FAIL wrap_acc1 got=%h/%b want=00000000/0011", o_addr[1], o_be[1]); end
      total++; if (o_rdata !== 32'h99995678) begin bad++; $display("FAIL wrap_rdata got=%h want=99995678", o_rdata); end
   endtask

   task automatic test_gnt_hold();
      run_txn(1'b1, 3'b001, 32'h207, 32'h0000A5B6, 32'h0, 32'h0, 0, 5);
      total++; if (o_unstable !== 0) begin bad++; $display("FAIL hold_stable got=%0d want=0", o_unstable); end
      total++; if (o_addr[0] !== 32'h204 || o_be[0] !== 4'b1000 || (o_wd[0] & 32'hFF000000) !== 32'hB6000000) begin bad++;
         $display("FAIL hold_acc0 got=%h/%b/%h want=00000204/1000/b6xxxxxx", o_addr[0], o_be[0], o_wd[0]); end
      total++; if (o_addr[1] !== 32'h208 || o_be[1] !== 4'b0001 || (o_wd[1] & 32'h000000FF) !== 32'h000000A5) begin bad++;
         $display("FAIL hold_acc1 got=%h/%b/%h want=00000208/0001/xxxxxxa5", o_addr[1], o_be[1], o_wd[1]); end
      total++; if (o_lat !== 11) begin bad++; $display("FAIL hold_latency got=%0d want=11", o_lat); end
   endtask

   task automatic test_back_to_back();
      run_txn(1'b0, 3'b100, 32'h3, 32'h0, 32'h7F000000, 32'h0, 0, 0);
      total++; if (o_rdata !== 32'h0000007F) begin bad++; $display("FAIL b2b_first got=%h want=0000007f", o_rdata); end
      run_txn(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 32'h0, 0, 0);
      total++; if (o_ready_at_req !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", o_ready_at_req); end
      total++; if (o_rdata !== 32'hCAFEF00D || o_lat !== 4) begin bad++;
         $display("FAIL b2b_second got=%h/%0d want=cafef00d/4", o_rdata, o_lat); end
   endtask

   task automatic test_reset_mid();
      int spur;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b001; req_addr_i = 32'h103;
      @(negedge clk_i); req_valid_i = 1'b0;
      total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL rmid_acc0 got=%b want=1", mem_req_o); end
      mem_gnt_i = 1'b1; @(negedge clk_i);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80112233; @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104) begin bad++;
         $display("FAIL rmid_acc1 got=%b/%h want=1/00000104", mem_req_o, mem_addr_o); end
      mem_gnt_i = 1'b1; @(negedge clk_i);
      mem_gnt_i = 1'b0;
      rst_ni = 1'b0; #1;
      total++; if (mem_req_o !== 1'b0 || rsp_valid_o !== 1'b0) begin bad++;
         $display("FAIL rmid_async got=%b/%b want=0/0", mem_req_o, rsp_valid_o); end
      @(negedge clk_i); rst_ni = 1'b1;
      @(negedge clk_i); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h4455667F;
      @(negedge clk_i); mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      spur = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid_o !== 1'b0 || mem_req_o !== 1'b0) spur++;
         @(negedge clk_i);
      end
      total++; if (spur !== 0) begin bad++; $display("FAIL rmid_late got=%0d want=0", spur); end
      total++; if (req_ready_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin bad++;
         $display("FAIL rmid_idle got=%b/%h want=1/00000000", req_ready_o, rsp_rdata_o); end
      run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'h0BADF00D, 32'h0, 0, 0);
      total++; if (o_rdata !== 32'h0BADF00D || o_nacc !== 1) begin bad++;
         $display("FAIL rmid_recover got=%h/%0d want=0badf00d/1", o_rdata, o_nacc); end
   endtask

   initial begin
      test_reset();
      test_lw_aligned();
      test_lh_split();
      test_sw_split();
      test_byte_loads();
      test_wrap();
      test_gnt_hold();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
